// File: rtl/pkt_fifo_arb.sv
// Bank of per-channel packet FIFOs drained by a round-robin arbiter into a
// single registered output stage with a valid/ready handshake.
module pkt_fifo_arb #(
  parameter int PCKG_SZ   = 40,
  parameter int DEEP_FIFO = 8,
  parameter int NUM_CH    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         push,
  input  logic [NUM_CH*PCKG_SZ-1:0] d_in,
  output logic [NUM_CH-1:0]         full,
  output logic [NUM_CH-1:0]         pndng,
  output logic [PCKG_SZ-1:0]        d_out,
  output logic [$clog2(NUM_CH)-1:0] d_out_src,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               drop_cnt
);

  localparam int PW = $clog2(DEEP_FIFO);
  localparam int CW = $clog2(DEEP_FIFO + 1);
  localparam int SW = $clog2(NUM_CH);
  localparam int DW = $clog2(NUM_CH + 1);

  logic [PCKG_SZ-1:0] mem    [NUM_CH][DEEP_FIFO];
  logic [PW-1:0]      wr_ptr [NUM_CH];
  logic [PW-1:0]      rd_ptr [NUM_CH];
  logic [CW-1:0]      count  [NUM_CH];
  logic [SW-1:0]      last_grant;
  logic [SW-1:0]      grant;
  logic               grant_any;
  logic               load;
  logic [NUM_CH-1:0]  pop;
  logic [NUM_CH-1:0]  wr_en;
  logic [NUM_CH-1:0]  drop;
  logic [DW-1:0]      drop_num;
  logic [16:0]        drop_sum;
  int                 idx;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      full[k]  = (count[k] == CW'(DEEP_FIFO));
      pndng[k] = (count[k] != '0);
    end
  end

  assign load = !out_valid || out_ready;

  // Search starts one past the last winner so every pending channel is reached within NUM_CH grants.
  always_comb begin
    grant     = last_grant;
    grant_any = 1'b0;
    idx       = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last_grant) + i) % NUM_CH;
      if (!grant_any && pndng[idx]) begin
        grant     = SW'(idx);
        grant_any = 1'b1;
      end
    end
  end

  // A pop in the same cycle frees the slot, so a push on a full channel is only lost without one.
  always_comb begin
    drop_num = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      pop[k]   = load && grant_any && (grant == SW'(k));
      wr_en[k] = push[k] && (!full[k] || pop[k]);
      drop[k]  = push[k] && full[k] && !pop[k];
      drop_num = drop_num + DW'(drop[k]);
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + 17'(drop_num);

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (wr_en[k]) mem[k][wr_ptr[k]] <= d_in[k*PCKG_SZ +: PCKG_SZ];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_en[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
        if (pop[k])   rd_ptr[k] <= rd_ptr[k] + 1'b1;
        if (wr_en[k] && !pop[k])      count[k] <= count[k] + 1'b1;
        else if (!wr_en[k] && pop[k]) count[k] <= count[k] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      d_out      <= '0;
      d_out_src  <= '0;
      last_grant <= SW'(NUM_CH - 1);
      drop_cnt   <= '0;
    end else begin
      if (load) begin
        if (grant_any) begin
          d_out      <= mem[grant][rd_ptr[grant]];
          d_out_src  <= grant;
          out_valid  <= 1'b1;
          last_grant <= grant;
        end else begin
          out_valid  <= 1'b0;
        end
      end
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_pkt_fifo_arb.sv
// Scoreboard bench for pkt_fifo_arb: a queue-based reference model predicts
// output packets and flags while a negedge monitor compares the DUT.
module tb_pkt_fifo_arb;

  localparam int W  = 40;
  localparam int D  = 8;
  localparam int N  = 4;
  localparam int SW = 2;

  logic           clk;
  logic           reset;
  logic [N-1:0]   push;
  logic [N*W-1:0] d_in;
  logic [N-1:0]   full;
  logic [N-1:0]   pndng;
  logic [W-1:0]   d_out;
  logic [SW-1:0]  d_out_src;
  logic           out_valid;
  logic           out_ready;
  logic [15:0]    drop_cnt;

  logic [W-1:0] mq [N][$];
  logic [W-1:0] expData [$];
  int           expSrc [$];
  bit           mvalid;
  int           mlast;
  int           mdrop;
  int           total;
  int           bad;

  pkt_fifo_arb #(.PCKG_SZ(W), .DEEP_FIFO(D), .NUM_CH(N)) dut (
    .clk(clk), .reset(reset), .push(push), .d_in(d_in), .full(full),
    .pndng(pndng), .d_out(d_out), .d_out_src(d_out_src),
    .out_valid(out_valid), .out_ready(out_ready), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[W-1:0];
  endfunction

  function automatic logic [N*W-1:0] rndBus();
    logic [N*W-1:0] b;
    for (int k = 0; k < N; k++) b[k*W +: W] = rnd();
    return b;
  endfunction

  // Reference: the output stage takes the next packet in round-robin order from
  // the contents held before this edge, then this edge's pushes are appended.
  task automatic modelStep(input logic [N-1:0] p, input logic [N*W-1:0] din, input logic rdy);
    int g;
    g = -1;
    if (!mvalid || rdy) begin
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (mlast + i) % N;
        if (g < 0 && mq[k].size() > 0) g = k;
      end
      if (g >= 0) begin
        expData.push_back(mq[g].pop_front());
        expSrc.push_back(g);
        mvalid = 1'b1;
        mlast  = g;
      end else begin
        mvalid = 1'b0;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (p[k]) begin
        if (mq[k].size() < D) mq[k].push_back(din[k*W +: W]);
        else if (mdrop < 65535) mdrop++;
      end
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] p, input logic [N*W-1:0] din, input logic rdy);
    push      = p;
    d_in      = din;
    out_ready = rdy;
    @(posedge clk);
    modelStep(p, din, rdy);
    #1;
  endtask

  task automatic checkOutput();
    for (int k = 0; k < N; k++) begin
      cmp($sformatf("full%0d", k), 64'(full[k]), 64'(mq[k].size() == D));
      cmp($sformatf("pndng%0d", k), 64'(pndng[k]), 64'(mq[k].size() != 0));
    end
    cmp("out_valid", 64'(out_valid), 64'(mvalid));
    cmp("drop_cnt", 64'(drop_cnt), 64'(mdrop));
    if (out_valid) begin
      if (expData.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL sb_empty: got out_valid=1 with d_out=%0h, expected no packet", d_out);
      end else begin
        cmp("d_out", 64'(d_out), 64'(expData[0]));
        cmp("d_out_src", 64'(d_out_src), 64'(expSrc[0]));
        if (out_ready) begin
          void'(expData.pop_front());
          void'(expSrc.pop_front());
        end
      end
    end
  endtask

  task automatic clearModel();
    for (int k = 0; k < N; k++) mq[k].delete();
    expData.delete();
    expSrc.delete();
    mvalid = 1'b0;
    mlast  = N - 1;
    mdrop  = 0;
  endtask

  // Asserts reset mid-cycle with pushes active and checks the outputs clear before any edge.
  task automatic resetMid();
    reset = 1'b1;
    push  = '1;
    d_in  = rndBus();
    #1;
    cmp("rst_out_valid", 64'(out_valid), 64'd0);
    cmp("rst_pndng", 64'(pndng), 64'd0);
    cmp("rst_full", 64'(full), 64'd0);
    cmp("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    cmp("rst_d_out", 64'(d_out), 64'd0);
    cmp("rst_d_out_src", 64'(d_out_src), 64'd0);
    clearModel();
    @(posedge clk);
    @(posedge clk);
    #1;
    push  = '0;
    reset = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) checkOutput();
    end
  end

  initial begin
    logic [N*W-1:0] b;
    total = 0;
    bad   = 0;
    clearModel();
    reset     = 1'b0;
    push      = '0;
    d_in      = '0;
    out_ready = 1'b0;
    #2;
    resetMid();

    b = '0;
    b[2*W +: W] = 40'hA5A5A5A5A5;
    applyStimulus(4'b0100, b, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus('0, '0, 1'b1);

    for (int i = 1; i <= 10; i++) begin
      b = '0;
      b[0 +: W] = W'(i);
      applyStimulus(4'b0001, b, 1'b0);
    end
    for (int i = 0; i < 12; i++) applyStimulus('0, '0, 1'b1);

    for (int i = 0; i < 2; i++) applyStimulus('1, rndBus(), 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus('0, '0, 1'b1);

    for (int i = 0; i < 10; i++) applyStimulus(4'b0010, rndBus(), 1'b0);
    applyStimulus(4'b0010, rndBus(), 1'b1);
    for (int i = 0; i < 14; i++) applyStimulus('0, '0, 1'b1);

    for (int c = 0; c < 3000; c++) begin
      logic rdy;
      if (((c / 200) % 2) == 0) rdy = ($urandom_range(0, 3) != 0);
      else                      rdy = ($urandom_range(0, 3) == 0);
      applyStimulus(N'($urandom_range(0, 15)), rndBus(), rdy);
    end

    for (int i = 0; i < 3; i++) applyStimulus('1, rndBus(), 1'b0);
    resetMid();

    for (int i = 0; i < 16400; i++) applyStimulus('1, rndBus(), 1'b0);
    cmp("drop_cnt_sat", 64'(drop_cnt), 64'hFFFF);

    for (int i = 0; i < 60; i++) applyStimulus('0, '0, 1'b1);
    total++;
    if (expData.size() != 0) begin
      bad++;
      $display("[TB] FAIL sb_leftover: got %0d packets never delivered, expected 0", expData.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
